// File: rtl/apb_bridge_4s.sv
// Single-requester CPU-to-APB3 bridge with four 2^REGION_BITS-byte slave regions above BASE_ADDR.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_bridge_4s #(
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int          REGION_BITS    = 12,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  output logic [3:0]  psel,
  output logic        penable,
  input  logic [31:0] prdata0,
  input  logic [31:0] prdata1,
  input  logic [31:0] prdata2,
  input  logic [31:0] prdata3,
  input  logic [3:0]  pready,
  input  logic [3:0]  pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  idx_q, idx_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        hit;
  logic        sel_ready;
  logic        sel_err;
  logic [31:0] sel_rdata;
  logic        done_ok;
  logic        timeout_hit;

  assign hit = (addr[31:REGION_BITS+2] == BASE_ADDR[31:REGION_BITS+2]);

  // Return path: only the captured slave's status and data are observed.
  always_comb begin
    sel_ready = pready[idx_q];
    sel_err   = pslverr[idx_q];
    case (idx_q)
      2'd0:    sel_rdata = prdata0;
      2'd1:    sel_rdata = prdata1;
      2'd2:    sel_rdata = prdata2;
      default: sel_rdata = prdata3;
    endcase
  end

  assign done_ok = (state_q == S_ACCESS) && sel_ready;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter holds the number of ACCESS cycles already completed; pready on the last one still wins.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_SETUP) begin
      cnt_d = '0;
    end else if (state_q == S_ACCESS) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (state_q == S_ACCESS) && !sel_ready &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req && hit) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (done_ok || timeout_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    psel    = 4'b0000;
    penable = 1'b0;
    if (state_q == S_SETUP || state_q == S_ACCESS) begin
      psel = 4'b0001 << idx_q;
    end
    if (state_q == S_ACCESS) begin
      penable = 1'b1;
    end
  end

  // Request capture and completion status; ready defaults low so it pulses for one cycle.
  always_comb begin
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    idx_d   = idx_q;
    ready_d = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (state_q == S_IDLE && req) begin
      if (hit) begin
        addr_d  = addr;
        we_d    = we;
        wdata_d = wdata;
        be_d    = be;
        idx_d   = addr[REGION_BITS+1:REGION_BITS];
      end else begin
        ready_d = 1'b1;
        err_d   = 1'b1;
        rdata_d = '0;
      end
    end
    if (done_ok) begin
      ready_d = 1'b1;
      err_d   = sel_err;
      rdata_d = we_q ? 32'h0 : sel_rdata;
    end else if (timeout_hit) begin
      ready_d = 1'b1;
      err_d   = 1'b1;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready  = ready_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign paddr  = addr_q;
  assign pwrite = we_q;
  assign pwdata = wdata_q;
  assign pstrb  = we_q ? be_q : 4'b0000;

endmodule

// File: tb/tb_apb_bridge_4s.sv
// Directed bench for apb_bridge_4s: write, waited read, decode misses, slave error with
// back-to-back issue, mid-transfer reset, and (with APB_TIMEOUT_EN) the ACCESS timeout.
module tb_apb_bridge_4s;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [3:0]  psel;
  logic        penable;
  logic [31:0] prdata0, prdata1, prdata2, prdata3;
  logic [3:0]  pready;
  logic [3:0]  pslverr;

  int errors = 0;
  int checks = 0;

  apb_bridge_4s #(
    .BASE_ADDR      (32'h1000_0000),
    .REGION_BITS    (12),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .be      (be),
    .ready   (ready),
    .rdata   (rdata),
    .err     (err),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .psel    (psel),
    .penable (penable),
    .prdata0 (prdata0),
    .prdata1 (prdata1),
    .prdata2 (prdata2),
    .prdata3 (prdata3),
    .pready  (pready),
    .pslverr (pslverr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
  endtask

  initial begin
    reset   = 1'b1;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    be      = '0;
    prdata0 = 32'hA0A0_A0A0;
    prdata1 = 32'hB1B1_B1B1;
    prdata2 = 32'hC2C2_C2C2;
    prdata3 = 32'h1234_5678;
    pready  = 4'hF;
    pslverr = 4'h0;

    step();
    step();
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    reset = 1'b0;

    // Zero-wait write to slave 2
    issue(1'b1, 32'h1000_2004, 32'hDEAD_BEEF, 4'hF);
    step();
    req = 1'b0;
    chk("wr_c1_psel", psel, 4'b0100);
    chk("wr_c1_penable", penable, 0);
    chk("wr_c1_paddr", paddr, 32'h1000_2004);
    chk("wr_c1_pstrb", pstrb, 4'hF);
    chk("wr_c1_pwrite", pwrite, 1);
    chk("wr_c1_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_c1_ready", ready, 0);
    step();
    chk("wr_c2_psel", psel, 4'b0100);
    chk("wr_c2_penable", penable, 1);
    chk("wr_c2_ready", ready, 0);
    step();
    chk("wr_c3_ready", ready, 1);
    chk("wr_c3_err", err, 0);
    chk("wr_c3_rdata", rdata, 0);
    chk("wr_c3_psel", psel, 0);
    step();
    chk("wr_c4_ready", ready, 0);

    // Read from slave 3 with 3 wait states; other slaves ready and erroring are ignored
    pready  = 4'b0111;
    pslverr = 4'b0111;
    issue(1'b0, 32'h1000_3010, 32'h0, 4'hF);
    step();
    req = 1'b0;
    chk("rd_c1_psel", psel, 4'b1000);
    chk("rd_c1_pstrb", pstrb, 4'h0);
    chk("rd_c1_pwrite", pwrite, 0);
    chk("rd_c1_paddr", paddr, 32'h1000_3010);
    for (int c = 2; c <= 5; c++) begin
      step();
      if (c == 5) pready = 4'hF;
      chk($sformatf("rd_c%0d_penable", c), penable, 1);
      chk($sformatf("rd_c%0d_psel", c), psel, 4'b1000);
      chk($sformatf("rd_c%0d_ready", c), ready, 0);
    end
    step();
    chk("rd_c6_ready", ready, 1);
    chk("rd_c6_err", err, 0);
    chk("rd_c6_rdata", rdata, 32'h1234_5678);
    chk("rd_c6_psel", psel, 0);
    pslverr = 4'h0;

    // Decode misses: far outside and one byte past the 16 KB window
    issue(1'b0, 32'h2000_0000, 32'h0, 4'hF);
    step();
    req = 1'b0;
    chk("miss1_psel", psel, 0);
    chk("miss1_ready", ready, 1);
    chk("miss1_err", err, 1);
    chk("miss1_rdata", rdata, 0);
    step();
    chk("miss1_c2_ready", ready, 0);
    chk("miss1_c2_psel", psel, 0);
    issue(1'b1, 32'h1000_4000, 32'h1111_2222, 4'hF);
    step();
    req = 1'b0;
    chk("miss2_psel", psel, 0);
    chk("miss2_ready", ready, 1);
    chk("miss2_err", err, 1);

    // Slave 1 error, then back-to-back write to slave 0 in the ready cycle
    step();
    pslverr = 4'b0010;
    issue(1'b0, 32'h1000_1008, 32'h0, 4'hF);
    step();
    req = 1'b0;
    chk("se_c1_psel", psel, 4'b0010);
    step();
    chk("se_c2_penable", penable, 1);
    step();
    chk("se_c3_ready", ready, 1);
    chk("se_c3_err", err, 1);
    chk("se_c3_rdata", rdata, 32'hB1B1_B1B1);
    issue(1'b1, 32'h1000_0000, 32'h55AA_33CC, 4'h3);
    step();
    req = 1'b0;
    pslverr = 4'h0;
    chk("b2b_c1_psel", psel, 4'b0001);
    chk("b2b_c1_pstrb", pstrb, 4'h3);
    chk("b2b_c1_pwdata", pwdata, 32'h55AA_33CC);
    chk("b2b_c1_ready", ready, 0);
    step();
    chk("b2b_c2_penable", penable, 1);
    step();
    chk("b2b_c3_ready", ready, 1);
    chk("b2b_c3_err", err, 0);
    chk("b2b_c3_rdata", rdata, 0);
    step();

    // Reset while waiting in ACCESS on slave 1
    pready = 4'b1101;
    issue(1'b0, 32'h1000_1000, 32'h0, 4'hF);
    step();
    req = 1'b0;
    step();
    chk("rm_pre_psel", psel, 4'b0010);
    chk("rm_pre_penable", penable, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rm_psel", psel, 0);
    chk("rm_penable", penable, 0);
    chk("rm_ready", ready, 0);
    chk("rm_paddr", paddr, 0);
    pready = 4'hF;
    step();
    step();
    chk("rm_noready", ready, 0);
    issue(1'b0, 32'h1000_2000, 32'h0, 4'hF);
    step();
    req = 1'b0;
    chk("rm_new_psel", psel, 4'b0100);
    step();
    step();
    chk("rm_new_ready", ready, 1);
    chk("rm_new_err", err, 0);
    chk("rm_new_rdata", rdata, 32'hC2C2_C2C2);
    step();

`ifdef APB_TIMEOUT_EN
    // Timeout after 4 ACCESS cycles with no pready
    pready = 4'h0;
    issue(1'b0, 32'h1000_3000, 32'h0, 4'hF);
    step();
    req = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      step();
      chk($sformatf("to_c%0d_penable", c), penable, 1);
      chk($sformatf("to_c%0d_ready", c), ready, 0);
    end
    step();
    chk("to_psel", psel, 0);
    chk("to_penable", penable, 0);
    chk("to_ready", ready, 1);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 0);
    step();
    // pready in the limit cycle completes normally
    issue(1'b0, 32'h1000_3000, 32'h0, 4'hF);
    step();
    req = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      step();
      if (c == 5) pready = 4'b1000;
    end
    step();
    chk("tow_ready", ready, 1);
    chk("tow_err", err, 0);
    chk("tow_rdata", rdata, 32'h1234_5678);
    pready = 4'hF;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_bridge_4s.md
Name: apb_bridge_4s

Overview:
- Bridges the CPU data-memory port (single outstanding request) onto an APB3-style peripheral bus with four slaves.
- The CPU side is one requester. The bridge decodes the address to one of four slave selects, runs the SETUP/ACCESS phases, then steers the selected slave's read data and status back to the CPU.
- It is the routing counterpart of the 4:1 data select used in writeback: one source fans out to four destinations, and the return path collapses 4:1.
- Sits between the load/store stage and the peripherals (GPIO, UART, timer, RAM window).

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the peripheral window; must be aligned to 4 x 2^REGION_BITS.
- REGION_BITS, 12, log2 of each slave's region size in bytes (4 KB per slave).
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  single-cycle request pulse from CPU; addr/we/wdata/be sampled with it
- we  in  1  1=write, 0=read
- addr  in  32  byte address
- wdata  in  32  write data
- be  in  4  byte enables
- ready  out  1  one-cycle completion pulse to CPU
- rdata  out  32  read data, valid when ready=1
- err  out  1  error status, valid when ready=1
- paddr  out  32  APB address (full captured addr)
- pwrite  out  1  APB direction
- pwdata  out  32  APB write data
- pstrb  out  4  APB strobes (be; 4'b0000 on reads)
- psel  out  4  one-hot slave select
- penable  out  1  APB enable
- prdata0..prdata3  in  32 each  slave read data
- pready  in  4  per-slave ready
- pslverr  in  4  per-slave error

Behaviour:
- Reset (synchronous, active-high): state=IDLE. ready=0, err=0, rdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0.
  - Reset asserted mid-transaction aborts it: all outputs return to these values at the next edge. No ready is issued for the aborted request.
- Decode:
  - Hit when addr[31:REGION_BITS+2] == BASE_ADDR[31:REGION_BITS+2].
  - idx = addr[REGION_BITS+1:REGION_BITS].
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE, req=1, hit: capture addr/we/wdata/be/idx into registers and go to SETUP.
  - IDLE, req=1, miss: no APB activity. Next cycle ready=1, err=1, rdata=0. Stay IDLE.
  - SETUP (1 cycle): psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb driven from the captured registers. Go to ACCESS.
  - ACCESS: psel[idx]=1, penable=1, address/control held stable.
    - If pready[idx]=1 at the edge: go to IDLE and register ready=1, err=pslverr[idx], rdata = we ? 0 : prdata[idx].
    - Otherwise remain in ACCESS.
    - pready/pslverr/prdata of unselected slaves are ignored.
- ready is high for exactly one cycle, the first IDLE cycle after completion.
- rdata/err hold their last value until the next completion; they are meaningful only when ready=1.
- Latency (zero-wait slave): req at cycle 0, SETUP cycle 1, ACCESS cycle 2, ready cycle 3. Each slave wait state adds 1 cycle.
- req while state!=IDLE is ignored; the CPU must not issue a new req before ready.
- req in the same cycle as ready=1 is accepted normally (back-to-back). It gives a 3-cycle issue interval.
- psel is one-hot or zero at all times. penable=1 only in ACCESS.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If it reaches TIMEOUT_CYCLES without pready[idx], the transfer is aborted: psel=0, penable=0, go to IDLE, next cycle ready=1, err=1, rdata=0.
  - pready arriving in the same cycle the limit is hit wins, giving a normal completion.
- Undefined: no counter; ACCESS waits indefinitely for pready[idx].

Test Plan:
- Write: req, we=1, addr=0x1000_2004, wdata=0xDEAD_BEEF, be=4'hF, pready=4'hF → cycle 1: psel=4'b0100, penable=0, paddr=0x1000_2004, pstrb=4'hF; cycle 2: penable=1; cycle 3: ready=1, err=0.
- Read with wait states: req, we=0, addr=0x1000_3010, pready[3] low for 3 ACCESS cycles, prdata3=0x1234_5678 → psel=4'b1000, pstrb=0, ready at cycle 6, rdata=0x1234_5678.
- Decode miss: req, addr=0x2000_0000 → psel stays 0, next cycle ready=1, err=1, rdata=0.
- Slave error plus back-to-back: read slave 1 with pslverr[1]=1 → ready with err=1; req held the same cycle to slave 0 → psel=4'b0001 the following cycle.
- Reset mid-ACCESS: reset=1 while psel=4'b0010, penable=1 → next edge psel=0, penable=0, ready=0; a new request afterwards completes normally.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=4, pready=0 → after 4 ACCESS cycles psel=0, then ready=1, err=1.
